mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Memory-access stage that consumes the decoded control bundle (MemRead, MemWrite, MemtoReg, RegWrite) and the ALU result. It drives a multi-cycle data-memory request/acknowledge interface and produces one writeback record per accepted instruction. While a memory transaction is outstanding it stalls upstream. Non-memory instructions pass through with fixed one-cycle latency.

Parameters:
DATA_W, 32, data and address width
REG_W, 5, register-index width
TIMEOUT, 16, REQ cycles without dmem_ack before the access is aborted (minimum 2)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  instruction bundle valid
in_ready  output  1  unit can accept a bundle this cycle
mem_read  input  1  MemRead control
mem_write  input  1  MemWrite control
mem_to_reg  input  1  MemtoReg control
reg_write  input  1  RegWrite control
write_reg  input  REG_W  destination register index
alu_result  input  DATA_W  effective address or ALU value
store_data  input  DATA_W  rt value for stores
stall  output  1  equals ~in_ready
dmem_req  output  1  memory request, held until ack or abort
dmem_we  output  1  1 = write, 0 = read; stable while dmem_req is high
dmem_addr  output  DATA_W  word address; stable while dmem_req is high
dmem_wdata  output  DATA_W  store data; stable while dmem_req is high
dmem_ack  input  1  memory completes the request this cycle
dmem_rdata  input  DATA_W  read data, valid with dmem_ack
out_valid  output  1  writeback record valid; one-cycle pulse
out_reg_write  output  1  writeback enable
out_write_reg  output  REG_W  writeback register index
out_wb_data  output  DATA_W  writeback data
err  output  1  one-cycle pulse alongside out_valid for a faulted access

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, timeout counter 0. All outputs 0 except in_ready, which is 1. Reset during REQ drops dmem_req immediately; no output record is produced.
- Accept: in_valid && in_ready at a rising edge latches all inputs.
- FSM states: IDLE, REQ, DONE.
- IDLE: in_ready=1.
  - If a bundle is accepted and it is a non-memory op: go to DONE.
  - If it is a legal, aligned memory op: go to REQ.
  - If it is illegal or misaligned: go to DONE with a fault.
- Illegal op: mem_read && mem_write. Misaligned op: a memory op with alu_result[1:0] != 0.
- Faults: no dmem request is issued. The record is emitted with out_reg_write=0 and err=1.
- REQ: dmem_req=1. dmem_we=latched mem_write, dmem_addr=latched alu_result, dmem_wdata=latched store_data. in_ready=0. The counter increments each REQ cycle.
  - dmem_ack high: capture dmem_rdata, clear the counter, go to DONE. An ack takes priority over timeout in the same cycle.
  - Otherwise, if the counter reaches TIMEOUT-1: drop the request, set the fault, clear the counter, go to DONE.
- DONE: out_valid=1 for exactly one cycle, in_ready=0, then go to IDLE.
  - out_wb_data = captured rdata if mem_to_reg, otherwise latched alu_result.
  - out_reg_write = latched reg_write && !fault.
  - out_write_reg = latched write_reg.
- Between records, out_* hold their last values while out_valid=0. err is 0 except in a DONE cycle for a faulted access.
- Latency: a non-memory op accepted at edge N gives out_valid in cycle N+1. A memory op acked in its k-th REQ cycle gives out_valid k+1 cycles after accept. Throughput is one bundle per 2 cycles at best.
- dmem_ack outside REQ is ignored.
- A store with reg_write=1 is honoured as given: this unit does not re-decode controls.

Test Plan:
- Reset mid-REQ: assert rst_n low two cycles into a load -> dmem_req=0 immediately, in_ready=1, no out_valid after release.
- R-type: accept alu_result=0x0000_0042, reg_write=1, write_reg=5 -> next cycle out_valid=1, out_wb_data=0x42, out_reg_write=1, out_write_reg=5, dmem_req never high.
- LW: accept addr=0x100, mem_read=1, mem_to_reg=1, write_reg=8; ack on the 3rd REQ cycle with rdata=0xDEADBEEF -> dmem_req high exactly 3 cycles, then out_wb_data=0xDEADBEEF, out_reg_write=1; stall high for 4 cycles.
- SW: accept addr=0x200, store_data=0x1234, mem_write=1, reg_write=0; ack on the 1st cycle -> dmem_we=1, dmem_wdata=0x1234 while the request is held, then out_valid with out_reg_write=0, err=0.
- Misaligned LW: addr=0x102 -> no dmem_req, next cycle out_valid=1, err=1, out_reg_write=0. Illegal read+write gives the same response.
- Timeout: LW with no ack, TIMEOUT=16 -> dmem_req high 16 cycles then low, out_valid=1, err=1, out_reg_write=0. Ack arriving on the 16th cycle instead -> normal completion, err=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-access stage of the pipeline.
// Takes the decoded memory controls and the ALU result, and runs a
// multi-cycle request/acknowledge exchange with data memory. It emits one
// writeback record for every bundle it accepts. Illegal or misaligned
// accesses never reach memory and come back as faulted records. A request
// that waits too long for an acknowledge is aborted and also faulted.
module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_to_reg,
    input  logic              reg_write,
    input  logic [REG_W-1:0]  write_reg,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              out_valid,
    output logic              out_reg_write,
    output logic [REG_W-1:0]  out_write_reg,
    output logic [DATA_W-1:0] out_wb_data,
    output logic              err
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               lat_mem_to_reg;
    logic               lat_reg_write;
    logic [REG_W-1:0]   lat_write_reg;
    logic [DATA_W-1:0]  rdata_q;

    logic               is_mem;
    logic               is_bad;

    // Classify the incoming bundle: memory op, and whether it must be faulted
    assign is_mem = mem_read | mem_write;
    assign is_bad = (mem_read & mem_write) | (is_mem & (alu_result[1:0] != 2'b00));

    assign stall = ~in_ready;

    // Single FSM: every output is registered and is updated on state transitions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            in_ready       <= 1'b1;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            out_valid      <= 1'b0;
            out_reg_write  <= 1'b0;
            out_write_reg  <= '0;
            out_wb_data    <= '0;
            err            <= 1'b0;
            lat_mem_to_reg <= 1'b0;
            lat_reg_write  <= 1'b0;
            lat_write_reg  <= '0;
            rdata_q        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready       <= 1'b0;
                        lat_mem_to_reg <= mem_to_reg;
                        lat_reg_write  <= reg_write;
                        lat_write_reg  <= write_reg;
                        if (is_mem && !is_bad) begin
                            // dmem_addr doubles as the latched ALU result for the writeback
                            state      <= REQ;
                            cnt        <= '0;
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_write;
                            dmem_addr  <= alu_result;
                            dmem_wdata <= store_data;
                        end else begin
                            state         <= DONE;
                            out_valid     <= 1'b1;
                            out_reg_write <= reg_write & ~is_bad;
                            out_write_reg <= write_reg;
                            out_wb_data   <= mem_to_reg ? rdata_q : alu_result;
                            err           <= is_bad;
                        end
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        state         <= DONE;
                        cnt           <= '0;
                        dmem_req      <= 1'b0;
                        rdata_q       <= dmem_rdata;
                        out_valid     <= 1'b1;
                        out_reg_write <= lat_reg_write;
                        out_write_reg <= lat_write_reg;
                        out_wb_data   <= lat_mem_to_reg ? dmem_rdata : dmem_addr;
                        err           <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state         <= DONE;
                        cnt           <= '0;
                        dmem_req      <= 1'b0;
                        out_valid     <= 1'b1;
                        out_reg_write <= 1'b0;
                        out_write_reg <= lat_write_reg;
                        out_wb_data   <= lat_mem_to_reg ? rdata_q : dmem_addr;
                        err           <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    err       <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit.
// Inputs are driven and outputs are sampled 1ns after each rising clock edge.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        out_valid;
    logic        out_reg_write;
    logic [4:0]  out_write_reg;
    logic [31:0] out_wb_data;
    logic        err;

    int checks;
    int failures;
    int reqCycles;
    int stallCycles;

    mem_access_unit #(.DATA_W(32), .REG_W(5), .TIMEOUT(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .write_reg     (write_reg),
        .alu_result    (alu_result),
        .store_data    (store_data),
        .stall         (stall),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .out_valid     (out_valid),
        .out_reg_write (out_reg_write),
        .out_write_reg (out_write_reg),
        .out_wb_data   (out_wb_data),
        .err           (err)
    );

    // 10ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction bundle onto the inputs
    task automatic applyStimulus(input logic v, input logic rd, input logic wr,
                                 input logic m2r, input logic rw, input logic [4:0] wreg,
                                 input logic [31:0] alu, input logic [31:0] sd);
        in_valid   = v;
        mem_read   = rd;
        mem_write  = wr;
        mem_to_reg = m2r;
        reg_write  = rw;
        write_reg  = wreg;
        alu_result = alu;
        store_data = sd;
    endtask

    // Compare a single-bit output against its expected value
    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Compare a word-wide output against its expected value
    task automatic checkWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        tick();
        tick();

        $display("[TB] reset state");
        checkOutput("rst_in_ready", in_ready, 1'b1);
        checkOutput("rst_stall", stall, 1'b0);
        checkOutput("rst_dmem_req", dmem_req, 1'b0);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_err", err, 1'b0);
        checkWord("rst_wb_data", out_wb_data, 32'h0);
        rst_n = 1'b1;
        tick();

        $display("[TB] R-type pass-through");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_0042, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        checkOutput("rtype_out_valid", out_valid, 1'b1);
        checkWord("rtype_wb_data", out_wb_data, 32'h42);
        checkOutput("rtype_reg_write", out_reg_write, 1'b1);
        checkWord("rtype_write_reg", 32'(out_write_reg), 32'd5);
        checkOutput("rtype_err", err, 1'b0);
        checkOutput("rtype_dmem_req", dmem_req, 1'b0);
        checkOutput("rtype_stall", stall, 1'b1);
        tick();
        checkOutput("rtype_pulse_end", out_valid, 1'b0);
        checkOutput("rtype_ready_again", in_ready, 1'b1);
        checkWord("rtype_wb_hold", out_wb_data, 32'h42);

        $display("[TB] load acked on third request cycle");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 32'h0000_0100, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        checkOutput("lw_req_c1", dmem_req, 1'b1);
        checkOutput("lw_we", dmem_we, 1'b0);
        checkWord("lw_addr", dmem_addr, 32'h100);
        stallCycles = 0;
        reqCycles   = 0;
        for (int i = 0; i < 3; i++) begin
            if (stall) stallCycles++;
            if (dmem_req) reqCycles++;
            checkOutput("lw_out_valid_low", out_valid, 1'b0);
            if (i == 2) begin
                dmem_ack   = 1'b1;
                dmem_rdata = 32'hDEAD_BEEF;
            end
            tick();
        end
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        if (stall) stallCycles++;
        if (dmem_req) reqCycles++;
        checkOutput("lw_out_valid", out_valid, 1'b1);
        checkWord("lw_wb_data", out_wb_data, 32'hDEAD_BEEF);
        checkOutput("lw_reg_write", out_reg_write, 1'b1);
        checkWord("lw_write_reg", 32'(out_write_reg), 32'd8);
        checkOutput("lw_err", err, 1'b0);
        checkWord("lw_req_cycles", reqCycles, 32'd3);
        tick();
        if (stall) stallCycles++;
        checkWord("lw_stall_cycles", stallCycles, 32'd4);

        $display("[TB] store acked on first request cycle");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 32'h0000_0200, 32'h0000_1234);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        checkOutput("sw_req", dmem_req, 1'b1);
        checkOutput("sw_we", dmem_we, 1'b1);
        checkWord("sw_wdata", dmem_wdata, 32'h1234);
        checkWord("sw_addr", dmem_addr, 32'h200);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        checkOutput("sw_req_dropped", dmem_req, 1'b0);
        checkOutput("sw_out_valid", out_valid, 1'b1);
        checkOutput("sw_reg_write", out_reg_write, 1'b0);
        checkOutput("sw_err", err, 1'b0);
        checkWord("sw_wb_data", out_wb_data, 32'h200);
        tick();

        $display("[TB] misaligned load");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h0000_0102, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        checkOutput("mis_dmem_req", dmem_req, 1'b0);
        checkOutput("mis_out_valid", out_valid, 1'b1);
        checkOutput("mis_err", err, 1'b1);
        checkOutput("mis_reg_write", out_reg_write, 1'b0);
        checkWord("mis_write_reg", 32'(out_write_reg), 32'd9);
        tick();
        checkOutput("mis_err_pulse_end", err, 1'b0);

        $display("[TB] illegal read+write");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd10, 32'h0000_0300, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        checkOutput("ill_dmem_req", dmem_req, 1'b0);
        checkOutput("ill_out_valid", out_valid, 1'b1);
        checkOutput("ill_err", err, 1'b1);
        checkOutput("ill_reg_write", out_reg_write, 1'b0);
        tick();

        $display("[TB] ack while idle is ignored");
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        checkOutput("idle_ack_out_valid", out_valid, 1'b0);
        checkOutput("idle_ack_ready", in_ready, 1'b1);

        $display("[TB] load timeout");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h0000_0400, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        reqCycles = 0;
        while (dmem_req && reqCycles < 40) begin
            reqCycles++;
            tick();
        end
        checkWord("to_req_cycles", reqCycles, 32'd16);
        checkOutput("to_out_valid", out_valid, 1'b1);
        checkOutput("to_err", err, 1'b1);
        checkOutput("to_reg_write", out_reg_write, 1'b0);
        tick();

        $display("[TB] load acked on last cycle before timeout");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 32'h0000_0404, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        repeat (15) tick();
        checkOutput("late_req_c16", dmem_req, 1'b1);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        checkOutput("late_out_valid", out_valid, 1'b1);
        checkOutput("late_err", err, 1'b0);
        checkOutput("late_reg_write", out_reg_write, 1'b1);
        checkWord("late_wb_data", out_wb_data, 32'hCAFE_F00D);
        tick();

        $display("[TB] reset during request");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h0000_0500, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        tick();
        checkOutput("rmid_req_before", dmem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("rmid_req_dropped", dmem_req, 1'b0);
        checkOutput("rmid_ready", in_ready, 1'b1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("rmid_no_record", out_valid, 1'b0);
            checkOutput("rmid_no_req", dmem_req, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
